// File: rtl/mem_read_ctrl.sv
// Memory-read sequencer: decodes the read address into a mux source select, inserts waits, latches data.
// Optional IO-ready timeout enabled by defining MRD_IO_TIMEOUT_EN.
module mem_read_ctrl #(
    parameter int MEM_WAIT   = 2,
    parameter int IO_TIMEOUT = 31
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [15:0] ADDR,
    output logic        ACK,
    output logic [15:0] SRC,
    input  logic [15:0] DATA_IN,
    input  logic        IO_READY,
    output logic [15:0] RDATA,
    output logic        VALID,
    input  logic        RDY,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_WAIT, ST_IOWAIT, ST_CAPTURE, ST_DONE
    } state_t;

    localparam logic [1:0] SRC_REG  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_IO   = 2'd2;
    localparam logic [1:0] SRC_ZERO = 2'd3;

    if (MEM_WAIT < 0 || MEM_WAIT > 15 || IO_TIMEOUT < 1 || IO_TIMEOUT > 255) begin : g_param_check
        $error("mem_read_ctrl: MEM_WAIT must be 0..15 and IO_TIMEOUT 1..255");
    end

    state_t      state, next_state;
    logic [1:0]  src_q;
    logic [3:0]  wait_cnt;
    logic [15:0] rdata_q;
    logic        valid_q;
    logic        ack_q;
    logic        timeout_hit;

    function automatic logic [1:0] decode(input logic [15:0] a);
        if (a[15:12] == 4'hF)      return SRC_REG;
        else if (!a[15])           return SRC_MEM;
        else if (a[15:12] == 4'hE) return SRC_IO;
        else                       return SRC_ZERO;
    endfunction

`ifdef MRD_IO_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       err_q;

    assign timeout_hit = (to_cnt == 8'(IO_TIMEOUT - 1));
    assign ERR         = err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_SETUP) to_cnt <= '0;
            else if (state == ST_IOWAIT) to_cnt <= to_cnt + 8'd1;
            if (state == ST_IOWAIT && !IO_READY && timeout_hit) err_q <= 1'b1;
            else if (state == ST_DONE && RDY) err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (REQ) next_state = ST_SETUP;
            ST_SETUP: begin
                case (src_q)
                    SRC_MEM: next_state = (MEM_WAIT == 0) ? ST_CAPTURE : ST_WAIT;
                    SRC_IO:  next_state = ST_IOWAIT;
                    default: next_state = ST_CAPTURE;
                endcase
            end
            ST_WAIT:    if (wait_cnt == 4'd0) next_state = ST_CAPTURE;
            // A ready strobe on the timeout cycle takes precedence over the error path.
            ST_IOWAIT: begin
                if (IO_READY)         next_state = ST_CAPTURE;
                else if (timeout_hit) next_state = ST_DONE;
            end
            ST_CAPTURE: next_state = ST_DONE;
            ST_DONE:    if (RDY) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            src_q    <= SRC_ZERO;
            wait_cnt <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        ack_q <= 1'b1;
                        src_q <= decode(ADDR);
                    end
                end
                ST_SETUP:  wait_cnt <= 4'(MEM_WAIT - 1);
                ST_WAIT:   if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                ST_IOWAIT: begin
                    if (!IO_READY && timeout_hit) begin
                        rdata_q <= '0;
                        valid_q <= 1'b1;
                        src_q   <= SRC_ZERO;
                    end
                end
                ST_CAPTURE: begin
                    rdata_q <= (src_q == SRC_ZERO) ? 16'h0000 : DATA_IN;
                    valid_q <= 1'b1;
                    src_q   <= SRC_ZERO;
                end
                ST_DONE:   if (RDY) valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ACK   = ack_q;
    assign SRC   = {14'b0, src_q};
    assign RDATA = rdata_q;
    assign VALID = valid_q;
    assign BUSY  = (state != ST_IDLE);

endmodule
